uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: pops one word from an external FIFO and serialises it as
// start, DATA_WIDTH data bits (LSB first), optional even parity, stop. Parity with UART_TX_PARITY_EN.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign shift_next = shift_reg >> 1;

  // tx, busy and fifo_rd_en are all registered here, so tx never glitches on a state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is an ordinary datapath register, not a memory, so it is cleared with the rest.
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge values of state and counters.
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= POP;
          end
        end

        POP: begin
          fifo_rd_en <= 1'b0;
          state      <= LOAD;
        end

        LOAD: begin
          shift_reg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_dout;
`endif
          bit_idx  <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_next;
              tx        <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          fifo_rd_en <= 1'b0;
          tx         <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: behavioural FIFO, line decoder with frame scoreboard,
// vector table plus hand sequences for reset, back-to-back, hold-off and mid-frame reset.
module tb_uart_tx;

  localparam int C = 4;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_dout  = '0;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;

  uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  fq[$];
  logic [31:0] exp_q[$];
  int          gap_q[$];
  int          rd_cnt = 0;
  int          rd_double = 0;
  int          rd_empty = 0;
  int          frames_done = 0;
  int          aborts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected line bits, bit k is the k-th bit on the wire.
  function automatic logic [31:0] frame_of(input logic [7:0] d, input logic p);
    logic [31:0] f;
`ifdef UART_TX_PARITY_EN
    f = {21'd0, 1'b1, p, d, 1'b0};
`else
    f = {22'd0, 1'b1, d, 1'b0};
    f[31] = p & 1'b0;
`endif
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic p);
    fq.push_back(d);
    fifo_empty = 1'b0;
    exp_q.push_back(frame_of(d, p));
  endtask

  task automatic wait_rd(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
    check(name, 32'(frames_done >= target), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: pop on an edge where rd_en was high; data valid from just after that edge.
  initial forever begin
    @(posedge clk);
    if (fifo_rd_en === 1'b1) begin
      #1;
      if (fq.size() > 0) fifo_dout = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  end

  initial begin
    bit prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        rd_cnt++;
        if (prev_rd) rd_double++;
        if (fifo_empty) rd_empty++;
      end
      prev_rd = (fifo_rd_en === 1'b1);
    end
  end

  // Line decoder: samples every cycle of every bit, so bit length and stability are checked exactly.
  initial begin
    int          last_end = 0;
    bit          have_end = 1'b0;
    bit          aborted;
    bit          stable;
    bit          got;
    logic [31:0] frame;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        if (have_end) gap_q.push_back(cyc - last_end - 1);
        aborted = 1'b0;
        stable  = 1'b1;
        frame   = '0;
        for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
          for (int s = 0; s < C; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (s == 0) frame[b] = tx;
            else if (tx !== frame[b]) stable = 1'b0;
          end
        end
        if (aborted) begin
          have_end = 1'b0;
          aborts++;
        end else begin
          last_end = cyc;
          have_end = 1'b1;
          check("bit_hold", 32'(stable), 32'd1);
          got = (exp_q.size() > 0);
          check("frame_expected", 32'(got), 32'd1);
          if (got) check("frame", frame, exp_q.pop_front());
          frames_done++;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   a5_seq[FRAME_BITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1,
`ifdef UART_TX_PARITY_EN
                                 0,
`endif
                                 1};
    int   r0, f0, a0, bad_tx, bad_busy;

    vecs[0] = '{8'h07, 1'b1};
    vecs[1] = '{8'h03, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h3C, 1'b0};
    vecs[7] = '{8'h7F, 1'b1};

    // Reset held for two edges.
    @(negedge clk);
    check("rst_cycle1", 32'({tx, busy, fifo_rd_en}), 32'b100);
    @(negedge clk);
    check("rst_cycle2", 32'({tx, busy, fifo_rd_en}), 32'b100);
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty FIFO hold-off.
    r0 = rd_cnt; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("holdoff_rd_en", 32'(rd_cnt - r0), 32'd0);
    check("holdoff_tx", 32'(bad_tx), 32'd0);
    check("holdoff_busy", 32'(bad_busy), 32'd0);

    // Single byte A5, cycle-exact.
    @(posedge clk);
    #1;
    r0 = rd_cnt;
    push_byte(8'hA5, 1'b0);
    wait_rd("a5_rd_en");
    @(negedge clk);
    check("a5_load", 32'({tx, busy}), 32'b11);
    bad_tx = 0; bad_busy = 0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int s = 0; s < C; s++) begin
        @(negedge clk);
        if (tx !== a5_seq[k][0]) bad_tx++;
        if (busy !== 1'b1) bad_busy++;
      end
    end
    check("a5_bits", 32'(bad_tx), 32'd0);
    check("a5_busy_frame", 32'(bad_busy), 32'd0);
    @(negedge clk);
    check("a5_busy_fall", 32'({tx, busy}), 32'b10);
    check("a5_rd_pulses", 32'(rd_cnt - r0), 32'd1);

    // Back-to-back AA, BB, CC.
    repeat (5) @(negedge clk);
    gap_q.delete();
    f0 = frames_done;
    r0 = rd_cnt;
    @(posedge clk);
    #1;
    push_byte(8'hAA, 1'b0);
    push_byte(8'hBB, 1'b0);
    push_byte(8'hCC, 1'b0);
    wait_frames(f0 + 3, 3 * FRAME_BITS * C + 60, "b2b_frames");
    repeat (20) @(negedge clk);
    check("b2b_rd_pulses", 32'(rd_cnt - r0), 32'd3);
    check("b2b_gap_count", 32'(gap_q.size()), 32'd3);
    check("b2b_gap2", 32'((gap_q.size() > 1) ? gap_q[1] : -1), 32'd3);
    check("b2b_gap3", 32'((gap_q.size() > 2) ? gap_q[2] : -1), 32'd3);

    // Reset during data bit 3 of 0F, then 55 must go out cleanly.
    f0 = frames_done;
    a0 = aborts;
    @(posedge clk);
    #1;
    push_byte(8'h0F, 1'b0);
    push_byte(8'h55, 1'b0);
    wait_rd("mid_rd_en");
    repeat (4 * C + 2) @(negedge clk);
    check("mid_in_bit3", 32'(tx), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_outputs", 32'({tx, busy, fifo_rd_en}), 32'b100);
    @(posedge clk);
    #1 rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("mid_abort_seen", 32'(aborts - a0), 32'd1);
    wait_frames(f0 + 1, FRAME_BITS * C + 60, "mid_next_frame");

    // Vector table, one frame each.
    foreach (vecs[i]) begin
      repeat (3) @(negedge clk);
      f0 = frames_done;
      @(posedge clk);
      #1;
      push_byte(vecs[i].data, vecs[i].par);
      wait_frames(f0 + 1, FRAME_BITS * C + 60, $sformatf("vec%0d_frame", i));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("rd_en_single_cycle", 32'(rd_double), 32'd0);
    check("rd_en_while_empty", 32'(rd_empty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
